// File: rtl/taillight_pkg.sv
// taillight_pkg: shared state enum, request classes, lamp patterns and counter-width helper.
package taillight_pkg;
  typedef enum logic [2:0] {IDLE, L1, L2, L3, R1, R2, R3, HAZ_ON} state_t;
  typedef enum logic [1:0] {REQ_NONE, REQ_L, REQ_R, REQ_HAZ} req_t;
  localparam logic [2:0] OFF = 3'b000;
  localparam logic [2:0] ONE = 3'b001;
  localparam logic [2:0] TWO = 3'b011;
  localparam logic [2:0] ALL = 3'b111;
  function automatic int tick_w(input int in_clock, input int step_hz);
    return (in_clock / step_hz > 1) ? $clog2(in_clock / step_hz) : 1;
  endfunction
  function automatic req_t state_cls(input state_t s);
    return (s == L1 || s == L2 || s == L3) ? REQ_L :
           (s == R1 || s == R2 || s == R3) ? REQ_R :
           (s == HAZ_ON) ? REQ_HAZ : REQ_NONE;
  endfunction
  function automatic logic [2:0] pattern(input state_t s);
    return (s == L1 || s == R1) ? ONE :
           (s == L2 || s == R2) ? TWO :
           (s == L3 || s == R3 || s == HAZ_ON) ? ALL : OFF;
  endfunction
endpackage

// File: rtl/step_tick.sv
// step_tick: 1-cycle step pulse every IN_CLOCK/STEP_HZ cycles; inClock/resetN in, clr restarts the period, tick out.
module step_tick import taillight_pkg::*; #(
  parameter int IN_CLOCK = 50000000,
  parameter int STEP_HZ  = 2
) (
  input  logic inClock,
  input  logic resetN,
  input  logic clr,
  output logic tick
);
  localparam int TICK_MAX = IN_CLOCK / STEP_HZ - 1;
  localparam int W = tick_w(IN_CLOCK, STEP_HZ);
  logic [W-1:0] cnt_q, cnt_d;
  assign tick = cnt_q == W'(TICK_MAX);
  always_comb cnt_d = (clr || tick) ? '0 : cnt_q + 1'b1;
  always_ff @(posedge inClock or negedge resetN)
    if (!resetN) cnt_q <= '0;
    else cnt_q <= cnt_d;
endmodule

// File: rtl/taillight_sequencer.sv
// taillight_sequencer: sequential turn/hazard/brake tail lights; switches left/right/hazard/brake in, lightsL/lightsR (bit0 inner) out.
module taillight_sequencer import taillight_pkg::*; #(
  parameter int IN_CLOCK = 50000000,
  parameter int STEP_HZ  = 2
) (
  input  logic       inClock,
  input  logic       resetN,
  input  logic       left,
  input  logic       right,
  input  logic       hazard,
  input  logic       brake,
  output logic [2:0] lightsL,
  output logic [2:0] lightsR
);
  logic [3:0] meta_q, sync_q;
  state_t     state_q, state_d;
  req_t       cls;
  logic       wait_q, wait_d, tick, clr, cancel;
  logic [2:0] pat, lights_l_d, lights_r_d;
  step_tick #(.IN_CLOCK(IN_CLOCK), .STEP_HZ(STEP_HZ)) u_tick (
    .inClock(inClock), .resetN(resetN), .clr(clr), .tick(tick)
  );
  // sync_q = {hazard, brake, right, left}
  always_comb begin
    cls = (sync_q[3] || (sync_q[0] && sync_q[1])) ? REQ_HAZ :
          sync_q[0] ? REQ_L : sync_q[1] ? REQ_R : REQ_NONE;
    state_d = state_q;
    wait_d = wait_q;
    cancel = 1'b0;
    if (state_q == IDLE) begin
      if (!wait_q || tick) begin
        wait_d = 1'b0;
        state_d = cls == REQ_HAZ ? HAZ_ON : cls == REQ_L ? L1 : cls == REQ_R ? R1 : IDLE;
      end
    end else if (cls != state_cls(state_q)) begin
      // class change: drop to the off step; the counter restarts so the off step is a full period
      state_d = IDLE;
      wait_d = cls != REQ_NONE;
      cancel = 1'b1;
    end else if (tick) begin
      state_d = state_q == L1 ? L2 : state_q == L2 ? L3 :
                state_q == R1 ? R2 : state_q == R2 ? R3 : IDLE;
      wait_d = state_d == IDLE;
    end
    clr = cancel || (state_q == IDLE && state_d != IDLE);
    pat = pattern(state_d);
    // turning/hazard side follows its sequence (including the off step); the other side is brake-only
    lights_l_d = (cls == REQ_HAZ || cls == REQ_L) ? pat : {3{sync_q[2]}};
    lights_r_d = (cls == REQ_HAZ || cls == REQ_R) ? pat : {3{sync_q[2]}};
  end
  always_ff @(posedge inClock or negedge resetN)
    if (!resetN) begin
      meta_q  <= '0;
      sync_q  <= '0;
      state_q <= IDLE;
      wait_q  <= 1'b0;
      lightsL <= OFF;
      lightsR <= OFF;
    end else begin
      meta_q  <= {hazard, brake, right, left};
      sync_q  <= meta_q;
      state_q <= state_d;
      wait_q  <= wait_d;
      lightsL <= lights_l_d;
      lightsR <= lights_r_d;
    end
endmodule

// File: tb/tb_taillight_sequencer.sv
// tb_taillight_sequencer: directed stimulus with a per-cycle behavioural model plus literal checkpoints.
module tb_taillight_sequencer;
  logic clk = 1'b0, resetN = 1'b0;
  logic left = 1'b0, right = 1'b0, hazard = 1'b0, brake = 1'b0;
  logic [2:0] lightsL, lightsR;
  int checks = 0, errors = 0;
  localparam int NONE = 0, LT = 1, RT = 2, HAZ = 3;
  logic [3:0] s1 = '0, s2 = '0;
  int age = 0, mcls = NONE, mstep = 0, cls = NONE;
  bit mwait = 0, tk = 0, clear = 0;
  logic [2:0] m_l = '0, m_r = '0, pat = '0;

  taillight_sequencer #(.IN_CLOCK(8), .STEP_HZ(2)) dut (
    .inClock(clk), .resetN(resetN), .left(left), .right(right),
    .hazard(hazard), .brake(brake), .lightsL(lightsL), .lightsR(lightsR)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [5:0] act, input logic [5:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic edges(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Model: step index 1..3 lights (1<<step)-1 lamps; a step lasts 4 cycles counted from the last restart.
  always @(posedge clk) begin
    if (!resetN) begin
      s1 = '0; s2 = '0; age = 0; mcls = NONE; mstep = 0; mwait = 0; m_l = '0; m_r = '0;
    end else begin
      cls = (s2[3] || (s2[0] && s2[1])) ? HAZ : s2[0] ? LT : s2[1] ? RT : NONE;
      tk = (age % 4) == 3;
      clear = 0;
      if (mcls == NONE) begin
        if (!mwait || tk) begin
          mwait = 0;
          if (cls != NONE) begin mcls = cls; mstep = 1; clear = 1; end
        end
      end else if (cls != mcls) begin
        mcls = NONE; mwait = (cls != NONE); clear = 1;
      end else if (tk) begin
        if (mcls == HAZ || mstep == 3) begin mcls = NONE; mwait = 1; end
        else mstep++;
      end
      age = clear ? 0 : age + 1;
      pat = mcls == HAZ ? 3'b111 : mcls != NONE ? 3'((1 << mstep) - 1) : 3'b000;
      m_l = (cls == HAZ || cls == LT) ? pat : (s2[2] ? 3'b111 : 3'b000);
      m_r = (cls == HAZ || cls == RT) ? pat : (s2[2] ? 3'b111 : 3'b000);
      s2 = s1;
      s1 = {hazard, brake, right, left};
    end
    #1;
    chk("model", {lightsL, lightsR}, {m_l, m_r});
  end

  initial begin
    edges(3);
    chk("reset_l", {3'b0, lightsL}, 6'b000000);
    chk("reset_r", {3'b0, lightsR}, 6'b000000);
    resetN = 1'b1;
    left = 1'b1;
    edges(2); chk("latency", {lightsL, lightsR}, 6'b000_000);
    edges(1); chk("left_1", {lightsL, lightsR}, 6'b001_000);
    edges(4); chk("left_2", {lightsL, lightsR}, 6'b011_000);
    edges(4); chk("left_3", {lightsL, lightsR}, 6'b111_000);
    edges(4); chk("left_off", {lightsL, lightsR}, 6'b000_000);
    edges(4); chk("left_again", {lightsL, lightsR}, 6'b001_000);
    left = 1'b0;
    edges(6);
    left = 1'b1; brake = 1'b1;
    edges(3); chk("brake_left", {lightsL, lightsR}, 6'b001_111);
    edges(6);
    left = 1'b0;
    edges(3); chk("brake_release", {lightsL, lightsR}, 6'b111_111);
    edges(3);
    brake = 1'b0;
    edges(4);
    left = 1'b1; right = 1'b1;
    edges(3); chk("lr_on", {lightsL, lightsR}, 6'b111_111);
    edges(4); chk("lr_off", {lightsL, lightsR}, 6'b000_000);
    edges(4); chk("lr_on2", {lightsL, lightsR}, 6'b111_111);
    brake = 1'b1;
    edges(4); chk("lr_brake_off", {lightsL, lightsR}, 6'b000_000);
    edges(4); chk("lr_brake_on", {lightsL, lightsR}, 6'b111_111);
    left = 1'b0; right = 1'b0; brake = 1'b0;
    edges(6);
    right = 1'b1;
    edges(3); chk("right_1", {lightsL, lightsR}, 6'b000_001);
    edges(4); chk("right_2", {lightsL, lightsR}, 6'b000_011);
    right = 1'b0; left = 1'b1;
    edges(3); chk("switch_idle", {lightsL, lightsR}, 6'b000_000);
    edges(3); chk("switch_hold", {lightsL, lightsR}, 6'b000_000);
    edges(1); chk("switch_left_1", {lightsL, lightsR}, 6'b001_000);
    edges(8); chk("pre_reset_l3", {lightsL, lightsR}, 6'b111_000);
    #2 resetN = 1'b0;
    #1 chk("async_reset", {lightsL, lightsR}, 6'b000_000);
    left = 1'b0;
    edges(2);
    resetN = 1'b1;
    edges(6); chk("post_reset", {lightsL, lightsR}, 6'b000_000);
    hazard = 1'b1;
    edges(3); chk("hazard_on", {lightsL, lightsR}, 6'b111_111);
    hazard = 1'b0;
    edges(5);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
